controller_link: RTL and testbench

CONTROLLER_LINK -- requirements
Module: controller_link

---
 rtl/controller_pkg.sv | 24 ++
 rtl/cdc_sync_edge.sv | 41 ++++
 rtl/controller_link.sv | 176 +++++++++++++++++
 tb/tb_controller_link.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// Shared types and constants for the controller serial link.
// Frame layout after the start bit (MSB first): port, buttons, parity.
package controller_pkg;

    localparam int CTRL_PORTS      = 4;
    localparam int CTRL_FRAME_BITS = 19;
    localparam int CTRL_BTN_BITS   = 16;
    localparam int CTRL_PORT_BITS  = $clog2(CTRL_PORTS);

    typedef logic [CTRL_BTN_BITS-1:0] controller_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2,
        ACK   = 2'd3
    } controller_fsm_t;

    // Even parity over the whole frame, parity bit included
    function automatic logic frame_parity_ok(input logic [CTRL_FRAME_BITS-1:0] frame);
        return ~(^frame);
    endfunction

endpackage

// File: rtl/cdc_sync_edge.sv
// Multi-flop synchroniser with a history flop and registered rise/fall strobes.
// level is the history flop, so it lines up with the registered strobes.
module cdc_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;
    logic                   rise_r;
    logic                   fall_r;

    // Synchroniser chain, history flop and edge strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            hist_r <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            sync_r[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            hist_r <= sync_r[SYNC_STAGES-1];
            rise_r <= sync_r[SYNC_STAGES-1] & ~hist_r;
            fall_r <= ~sync_r[SYNC_STAGES-1] & hist_r;
        end
    end

    assign level = hist_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/controller_link.sv
// Serial link receiver for a controller microcontroller: frames carry a port
// number and 16 button bits, are parity-checked, acknowledged and stored.
module controller_link
    import controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                                Clk,
    input  logic                                Reset_n,
    input  logic                                ControllerClk,
    input  logic                                ControllerIn,
    output logic                                ControllerOut,
    input  logic                                Clear,
    output controller_state_t [CTRL_PORTS-1:0]  Buttons,
    output logic                                FrameValid,
    output logic [CTRL_PORT_BITS-1:0]           FramePort,
    output logic                                ParityError,
    output logic                                Timeout
);

    localparam int CNT_W  = $clog2(CTRL_FRAME_BITS);
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CTRL_FRAME_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1);

    logic clk_rise_s, clk_fall_s, clk_level_s;
    logic data_s, data_rise_s, data_fall_s;
    logic unused_ok_s;

    controller_fsm_t                    state_r, state_s;
    logic [CNT_W-1:0]                   bit_cnt_r, bit_cnt_s;
    logic [CTRL_FRAME_BITS-1:0]         shift_r, shift_s;
    logic [TCNT_W-1:0]                  tcnt_r, tcnt_s;
    controller_state_t [CTRL_PORTS-1:0] buttons_r;
    logic [CTRL_PORT_BITS-1:0]          frame_port_r;
    logic ctrl_out_r, ctrl_out_s;
    logic frame_valid_r, frame_valid_s;
    logic parity_error_r, parity_error_s;
    logic timeout_r, timeout_s;
    logic accept_s, timeout_hit_s;

    cdc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk(Clk), .rst_n(Reset_n), .din(ControllerClk),
        .level(clk_level_s), .rise(clk_rise_s), .fall(clk_fall_s)
    );

    cdc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
        .clk(Clk), .rst_n(Reset_n), .din(ControllerIn),
        .level(data_s), .rise(data_rise_s), .fall(data_fall_s)
    );

    // The data line's strobes and the clock line's level are not used
    assign unused_ok_s = ^{clk_level_s, data_rise_s, data_fall_s};

    // Next-state, shift/counter updates and pulse generation
    always_comb begin
        state_s        = state_r;
        bit_cnt_s      = bit_cnt_r;
        shift_s        = shift_r;
        ctrl_out_s     = ctrl_out_r;
        frame_valid_s  = 1'b0;
        parity_error_s = 1'b0;
        timeout_s      = 1'b0;
        accept_s       = 1'b0;
        timeout_hit_s  = (tcnt_r == TCNT_LAST);
        case (state_r)
            IDLE: begin
                if (clk_rise_s && data_s) begin
                    state_s   = SHIFT;
                    bit_cnt_s = {CNT_W{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (timeout_hit_s) begin
                    timeout_s  = 1'b1;
                    ctrl_out_s = 1'b0;
                    state_s    = IDLE;
                end else if (clk_rise_s) begin
                    shift_s   = {shift_r[CTRL_FRAME_BITS-2:0], data_s};
                    bit_cnt_s = bit_cnt_r + CNT_ONE;
                    if (bit_cnt_r == CNT_LAST) begin
                        state_s = CHECK;
                    end else begin
                        state_s = SHIFT;
                    end
                end else begin
                    state_s = SHIFT;
                end
            end
            CHECK: begin
                if (frame_parity_ok(shift_r)) begin
                    accept_s      = 1'b1;
                    frame_valid_s = 1'b1;
                    ctrl_out_s    = 1'b1;
                    state_s       = ACK;
                end else begin
                    parity_error_s = 1'b1;
                    state_s        = IDLE;
                end
            end
            ACK: begin
                if (timeout_hit_s) begin
                    timeout_s  = 1'b1;
                    ctrl_out_s = 1'b0;
                    state_s    = IDLE;
                end else if (clk_fall_s) begin
                    ctrl_out_s = 1'b0;
                    state_s    = IDLE;
                end else begin
                    state_s = ACK;
                end
            end
            default: begin
                ctrl_out_s = 1'b0;
                state_s    = IDLE;
            end
        endcase

        // Inactivity counter only runs while waiting on the microcontroller
        if ((state_r == SHIFT || state_r == ACK) && !timeout_hit_s && !(clk_rise_s || clk_fall_s)) begin
            tcnt_s = tcnt_r + TCNT_ONE;
        end else begin
            tcnt_s = {TCNT_W{1'b0}};
        end
    end

    // State, datapath and output registers; Clear overrides a same-cycle store
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r        <= IDLE;
            bit_cnt_r      <= {CNT_W{1'b0}};
            shift_r        <= {CTRL_FRAME_BITS{1'b0}};
            tcnt_r         <= {TCNT_W{1'b0}};
            buttons_r      <= {(CTRL_PORTS*CTRL_BTN_BITS){1'b0}};
            frame_port_r   <= {CTRL_PORT_BITS{1'b0}};
            ctrl_out_r     <= 1'b0;
            frame_valid_r  <= 1'b0;
            parity_error_r <= 1'b0;
            timeout_r      <= 1'b0;
        end else begin
            state_r        <= state_s;
            bit_cnt_r      <= bit_cnt_s;
            shift_r        <= shift_s;
            tcnt_r         <= tcnt_s;
            ctrl_out_r     <= ctrl_out_s;
            frame_valid_r  <= frame_valid_s;
            parity_error_r <= parity_error_s;
            timeout_r      <= timeout_s;
            if (Clear) begin
                buttons_r <= {(CTRL_PORTS*CTRL_BTN_BITS){1'b0}};
            end else if (accept_s) begin
                buttons_r[shift_r[CTRL_FRAME_BITS-1 -: CTRL_PORT_BITS]] <= shift_r[CTRL_BTN_BITS:1];
            end else begin
                buttons_r <= buttons_r;
            end
            if (accept_s) begin
                frame_port_r <= shift_r[CTRL_FRAME_BITS-1 -: CTRL_PORT_BITS];
            end else begin
                frame_port_r <= frame_port_r;
            end
        end
    end

    assign Buttons       = buttons_r;
    assign FramePort     = frame_port_r;
    assign ControllerOut = ctrl_out_r;
    assign FrameValid    = frame_valid_r;
    assign ParityError   = parity_error_r;
    assign Timeout       = timeout_r;

endmodule

// File: tb/tb_controller_link.sv
// Directed bench for controller_link: good/bad frames, timeout, Clear race,
// mid-frame reset and back-to-back frames, with hand-derived expectations.
module tb_controller_link;
    import controller_pkg::*;

    localparam int TO = 64;
    localparam int SS = 2;
    localparam int LAT = SS + 2;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic ControllerClk = 1'b0;
    logic ControllerIn = 1'b0;
    logic Clear = 1'b0;
    logic ControllerOut, FrameValid, ParityError, Timeout;
    logic [1:0] FramePort;
    controller_state_t [CTRL_PORTS-1:0] Buttons;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0, pe_cnt = 0, to_cnt = 0, multi_cnt = 0;

    always #5 Clk = ~Clk;

    controller_link #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(SS)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .ControllerClk(ControllerClk),
        .ControllerIn(ControllerIn), .ControllerOut(ControllerOut), .Clear(Clear),
        .Buttons(Buttons), .FrameValid(FrameValid), .FramePort(FramePort),
        .ParityError(ParityError), .Timeout(Timeout)
    );

    // Pulse monitor
    always @(negedge Clk) begin
        if (FrameValid === 1'b1) fv_cnt <= fv_cnt + 1;
        if (ParityError === 1'b1) pe_cnt <= pe_cnt + 1;
        if (Timeout === 1'b1) to_cnt <= to_cnt + 1;
        if (int'(FrameValid) + int'(ParityError) + int'(Timeout) > 1) multi_cnt <= multi_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] frame_word(input logic [1:0] p, input logic [15:0] b, input logic bad);
        return {1'b1, p, b, (^{p, b}) ^ bad};
    endfunction

    // One bit at Clk/8: data and clock low for 4 cycles, clock high for 4
    task automatic send_bit(input logic b);
        @(negedge Clk);
        ControllerIn = b;
        ControllerClk = 1'b0;
        repeat (4) @(negedge Clk);
        ControllerClk = 1'b1;
        repeat (4) @(negedge Clk);
    endtask

    task automatic send_bits(input logic [19:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(w[i]);
    endtask

    task automatic send_frame(input logic [1:0] p, input logic [15:0] b, input logic bad,
                              input logic do_clear, output int lat_fv, output int lat_pe,
                              output logic co_any, output logic co_end);
        logic [19:0] w;
        w = frame_word(p, b, bad);
        send_bits(w, 19, 1);
        @(negedge Clk);
        ControllerIn = w[0];
        ControllerClk = 1'b0;
        repeat (4) @(negedge Clk);
        ControllerClk = 1'b1;
        lat_fv = -1;
        lat_pe = -1;
        co_any = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge Clk);
            #1;
            if (FrameValid === 1'b1 && lat_fv < 0) lat_fv = k;
            if (ParityError === 1'b1 && lat_pe < 0) lat_pe = k;
            if (ControllerOut === 1'b1) co_any = 1'b1;
            if (do_clear) Clear = (k == SS + 1);
        end
        co_end = ControllerOut;
        @(negedge Clk);
        ControllerClk = 1'b0;
        repeat (8) @(negedge Clk);
    endtask

    initial begin
        int lf, lp, f0, p0, t0, k;
        logic ca, ce;
        logic [15:0] vals [4];
        vals[0] = 16'h1357; vals[1] = 16'h2468; vals[2] = 16'h9ABC; vals[3] = 16'hDEF0;

        repeat (4) @(negedge Clk);
        chk("rst_out", {31'd0, ControllerOut}, 32'd0);
        chk("rst_port", {30'd0, FramePort}, 32'd0);
        chk("rst_pulses", {29'd0, FrameValid, ParityError, Timeout}, 32'd0);
        for (int i = 0; i < 4; i++) chk("rst_buttons", {16'd0, Buttons[i]}, 32'd0);
        Reset_n = 1'b1;
        repeat (4) @(negedge Clk);

        // Good frame to port 2
        f0 = fv_cnt;
        send_frame(2'd2, 16'hA5C3, 1'b0, 1'b0, lf, lp, ca, ce);
        chk("good_latency", lf, LAT);
        chk("good_ack_high", {31'd0, ce}, 32'd1);
        chk("good_ack_low", {31'd0, ControllerOut}, 32'd0);
        chk("good_count", fv_cnt - f0, 32'd1);
        chk("good_port", {30'd0, FramePort}, 32'd2);
        chk("good_btn2", {16'd0, Buttons[2]}, 32'h0000A5C3);
        chk("good_btn0", {16'd0, Buttons[0]}, 32'd0);
        chk("good_btn1", {16'd0, Buttons[1]}, 32'd0);
        chk("good_btn3", {16'd0, Buttons[3]}, 32'd0);

        // Same frame, parity bit inverted
        f0 = fv_cnt; p0 = pe_cnt;
        send_frame(2'd2, 16'hA5C3, 1'b1, 1'b0, lf, lp, ca, ce);
        chk("bad_pe_latency", lp, LAT);
        chk("bad_pe_count", pe_cnt - p0, 32'd1);
        chk("bad_no_fv", fv_cnt - f0, 32'd0);
        chk("bad_ack_never", {31'd0, ca}, 32'd0);
        chk("bad_btn2", {16'd0, Buttons[2]}, 32'h0000A5C3);

        // Ten bits then the clock stops
        t0 = to_cnt;
        send_bits(frame_word(2'd1, 16'h0F0F, 1'b0), 19, 10);
        @(negedge Clk);
        ControllerClk = 1'b0;
        k = -1;
        for (int j = 0; j < TO + 40; j++) begin
            @(posedge Clk);
            #1;
            if (Timeout === 1'b1) begin
                k = j;
                break;
            end
        end
        chk("timeout_latency", k, TO + SS + 1);
        repeat (4) @(negedge Clk);
        chk("timeout_count", to_cnt - t0, 32'd1);
        f0 = fv_cnt;
        send_frame(2'd1, 16'hFFFF, 1'b0, 1'b0, lf, lp, ca, ce);
        chk("after_to_latency", lf, LAT);
        chk("after_to_port", {30'd0, FramePort}, 32'd1);
        chk("after_to_btn1", {16'd0, Buttons[1]}, 32'h0000FFFF);

        // Clear coincides with the accept
        send_frame(2'd0, 16'h0001, 1'b0, 1'b1, lf, lp, ca, ce);
        chk("clear_fv", lf, LAT);
        chk("clear_port", {30'd0, FramePort}, 32'd0);
        for (int i = 0; i < 4; i++) chk("clear_btn", {16'd0, Buttons[i]}, 32'd0);

        // Back-to-back frames to every port
        f0 = fv_cnt;
        for (int p = 0; p < 4; p++) begin
            send_frame(2'(p), vals[p], 1'b0, 1'b0, lf, lp, ca, ce);
            chk("b2b_latency", lf, LAT);
            chk("b2b_port", {30'd0, FramePort}, p);
        end
        chk("b2b_count", fv_cnt - f0, 32'd4);
        for (int i = 0; i < 4; i++) chk("b2b_btn", {16'd0, Buttons[i]}, {16'd0, vals[i]});

        // Reset in the middle of a frame
        send_bits(frame_word(2'd3, 16'h1234, 1'b0), 19, 12);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        chk("midrst_port", {30'd0, FramePort}, 32'd0);
        chk("midrst_out", {31'd0, ControllerOut}, 32'd0);
        for (int i = 0; i < 4; i++) chk("midrst_btn", {16'd0, Buttons[i]}, 32'd0);
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        f0 = fv_cnt;
        send_bits(frame_word(2'd3, 16'h1234, 1'b0), 11, 0);
        @(negedge Clk);
        ControllerClk = 1'b0;
        repeat (TO + 20) @(negedge Clk);
        chk("midrst_no_fv", fv_cnt - f0, 32'd0);
        send_frame(2'd3, 16'h0F0F, 1'b0, 1'b0, lf, lp, ca, ce);
        chk("recover_latency", lf, LAT);
        chk("recover_btn3", {16'd0, Buttons[3]}, 32'h00000F0F);

        repeat (2) @(negedge Clk);
        chk("one_pulse_per_cycle", multi_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
